// File: rtl/pa_fdsu_seq_ctrl.sv
// pa_fdsu_seq_ctrl
// Sequencing controller for the single-precision FDSU divide/sqrt datapath.
// Takes one request at a time through INIT -> ITER -> RND -> PACK -> WB.
// Special operands (NaN/inf/zero) go straight from INIT to WB.
//
// Ports:
//   forever_cpuclk, cpurst      clock, synchronous active-high reset
//   req_vld/req_rdy             request handshake
//   req_sqrt/special/freg       request attributes, latched on accept
//   flush                       kills any in-flight op, returns to IDLE
//   srt_init, srt_iter_en,
//   srt_iter_cnt                SRT datapath controls
//   ex3_rnd_en, ex4_pack_en     round / pack stage strobes
//   fdsu_yy_*                   latched op attributes for the datapath
//   frbus_req/frbus_grant       result bus writeback handshake
//   wb_done                     completed writeback pulse
//   busy                        controller not idle
module pa_fdsu_seq_ctrl #(
    parameter int DIV_ITER  = 13,
    parameter int SQRT_ITER = 13,
    parameter int CNT_W     = 4
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             req_vld,
    input  logic             req_sqrt,
    input  logic             req_special,
    input  logic [4:0]       req_freg,
    output logic             req_rdy,
    input  logic             flush,
    output logic             srt_init,
    output logic             srt_iter_en,
    output logic [CNT_W-1:0] srt_iter_cnt,
    output logic             ex3_rnd_en,
    output logic             ex4_pack_en,
    output logic             fdsu_yy_op_sqrt,
    output logic             fdsu_yy_special,
    output logic [4:0]       fdsu_yy_wb_freg,
    output logic             frbus_req,
    input  logic             frbus_grant,
    output logic             wb_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        ITER = 3'd2,
        RND  = 3'd3,
        PACK = 3'd4,
        WB   = 3'd5
    } state_e;

    // Counter load values: the count includes the current iteration.
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_ITER - 1);
    localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_ITER - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sqrt_q, sqrt_d;
    logic             special_q, special_d;
    logic [4:0]       freg_q, freg_d;

    logic             accept;
    // Strobes are suppressed in a flush or reset cycle so the datapath
    // never sees a partial step of a killed operation.
    logic             strobe_ok;

    assign strobe_ok = !flush && !cpurst;
    assign req_rdy   = (state_q == IDLE) && strobe_ok;
    assign accept    = req_vld && req_rdy;

    assign srt_init    = (state_q == INIT) && strobe_ok;
    assign srt_iter_en = (state_q == ITER) && strobe_ok;
    assign ex3_rnd_en  = (state_q == RND)  && strobe_ok;
    assign ex4_pack_en = (state_q == PACK) && strobe_ok;
    assign frbus_req   = (state_q == WB)   && strobe_ok;
    // Grant only counts while requesting; a flush in the same cycle wins.
    assign wb_done     = frbus_req && frbus_grant;
    assign busy        = (state_q != IDLE);

    assign srt_iter_cnt    = cnt_q;
    assign fdsu_yy_op_sqrt = sqrt_q;
    assign fdsu_yy_special = special_q;
    assign fdsu_yy_wb_freg = freg_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sqrt_d    = sqrt_q;
        special_d = special_q;
        freg_d    = freg_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sqrt_d    = req_sqrt;
                    special_d = req_special;
                    freg_d    = req_freg;
                    state_d   = INIT;
                end
            end
            INIT: begin
                if (special_q) begin
                    state_d = WB;
                end else begin
                    cnt_d   = sqrt_q ? SQRT_LOAD : DIV_LOAD;
                    state_d = ITER;
                end
            end
            ITER: begin
                // Counter saturates at 0; the cnt==0 cycle is the last iteration.
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = RND;
            end
            RND:  state_d = PACK;
            PACK: state_d = WB;
            WB: begin
                if (frbus_grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush abandons the op; latched attributes are left untouched.
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sqrt_q    <= 1'b0;
            special_q <= 1'b0;
            freg_q    <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sqrt_q    <= sqrt_d;
            special_q <= special_d;
            freg_q    <= freg_d;
        end
    end

endmodule
